// File: rtl/join_merge_scheduler_if.sv
// Handshake and status bundle for the JOIN ring-entry merge scheduler.
// slave is the scheduler side; master is the environment driving requests and consuming packets.
interface join_merge_scheduler_if #(
  parameter int unsigned PACKET_WIDTH = 38,
  parameter int unsigned CNT_W        = 4
);
  logic                    Send_in_EX;
  logic [PACKET_WIDTH-1:0] PACKET_IN_EXTERNAL;
  logic                    Ack_out_EX;
  logic                    Send_in_IN;
  logic [PACKET_WIDTH-1:0] PACKET_IN_INTERNAL;
  logic                    Ack_out_IN;
  logic                    Send_out;
  logic [PACKET_WIDTH-1:0] PACKET_OUT;
  logic                    Ack_in;
  logic                    EXIT;
  logic [CNT_W-1:0]        INFLIGHT;
  logic                    ERR;

  modport slave (
    input  Send_in_EX, PACKET_IN_EXTERNAL, Send_in_IN, PACKET_IN_INTERNAL, Ack_in, EXIT,
    output Ack_out_EX, Ack_out_IN, Send_out, PACKET_OUT, INFLIGHT, ERR
  );

  modport master (
    output Send_in_EX, PACKET_IN_EXTERNAL, Send_in_IN, PACKET_IN_INTERNAL, Ack_in, EXIT,
    input  Ack_out_EX, Ack_out_IN, Send_out, PACKET_OUT, INFLIGHT, ERR
  );
endinterface

// File: rtl/join_merge_scheduler.sv
// Ring-entry merge of external and recirculated packets: internal priority with an
// anti-starvation bound, and external admission gated by an in-flight credit count.
module join_merge_scheduler #(
  parameter int unsigned PACKET_WIDTH = 38,
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input logic                   CP,
  input logic                   MR,
  join_merge_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] MaxInflight = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] StarveLimit = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StOutReq, StOutRel} state_e;

  state_e                  state_q, state_d;
  logic                    send_q, send_d;
  logic                    ack_ex_q, ack_ex_d;
  logic                    ack_in_q, ack_in_d;
  logic [PACKET_WIDTH-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0]        inflight_q, inflight_d;
  logic [CNT_W-1:0]        starve_q, starve_d;
  logic                    err_q, err_d;

  logic elig_in, elig_ex, grant_in, grant_ex, exit_ok;

  // A channel whose ack is still high has not finished its handshake and cannot win again.
  always_comb begin
    elig_in  = bus.Send_in_IN & ~ack_in_q;
    elig_ex  = bus.Send_in_EX & ~ack_ex_q & (inflight_q < MaxInflight);
    grant_in = 1'b0;
    grant_ex = 1'b0;
    if (state_q == StIdle) begin
      if (elig_ex && (!elig_in || starve_q == StarveLimit)) begin
        grant_ex = 1'b1;
      end else if (elig_in) begin
        grant_in = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    send_d  = send_q;
    pkt_d   = pkt_q;
    unique case (state_q)
      StIdle: begin
        if (grant_in || grant_ex) begin
          state_d = StOutReq;
          send_d  = 1'b1;
          pkt_d   = grant_ex ? bus.PACKET_IN_EXTERNAL : bus.PACKET_IN_INTERNAL;
        end
      end
      StOutReq: begin
        if (bus.Ack_in) begin
          state_d = StOutRel;
          send_d  = 1'b0;
        end
      end
      StOutRel: begin
        if (!bus.Ack_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ack_ex_d   = grant_ex | (ack_ex_q & bus.Send_in_EX);
    ack_in_d   = grant_in | (ack_in_q & bus.Send_in_IN);
    exit_ok    = bus.EXIT & (inflight_q != '0);
    inflight_d = inflight_q + CNT_W'(grant_ex) - CNT_W'(exit_ok);
    err_d      = err_q | (bus.EXIT & (inflight_q == '0));
    starve_d   = starve_q;
    if (grant_ex) begin
      starve_d = '0;
    end else if (grant_in && elig_ex && starve_q != StarveLimit) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      state_q    <= StIdle;
      send_q     <= 1'b0;
      ack_ex_q   <= 1'b0;
      ack_in_q   <= 1'b0;
      pkt_q      <= '0;
      inflight_q <= '0;
      starve_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      send_q     <= send_d;
      ack_ex_q   <= ack_ex_d;
      ack_in_q   <= ack_in_d;
      pkt_q      <= pkt_d;
      inflight_q <= inflight_d;
      starve_q   <= starve_d;
      err_q      <= err_d;
    end
  end

  assign bus.Send_out   = send_q;
  assign bus.Ack_out_EX = ack_ex_q;
  assign bus.Ack_out_IN = ack_in_q;
  assign bus.PACKET_OUT = pkt_q;
  assign bus.INFLIGHT   = inflight_q;
  assign bus.ERR        = err_q;

endmodule
